// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display path: glyph table, segment indices, polarity helper.
package display_pkg;

   localparam int SEG_W = 7;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Active-high gfedcba glyphs for 0-F; b and d are lowercase.
   localparam logic [SEG_W-1:0] HEX_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [SEG_W-1:0] apply_pol(input logic [SEG_W-1:0] v, input logic active_low);
      return active_low ? ~v : v;
   endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Nibble to active-high 7-segment glyph; purely combinational, zero latency, no flow control.
module hex_to_7seg
   import display_pkg::*;
(
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] glyph
);

   assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/display_7seg_scan.sv
// Multiplexed N-digit 7-segment scanner with blanking, leading-zero suppression and frame-aligned loads.
// Outputs are registered (one cycle after idx changes); load_ready drops while a word waits for the frame wrap.
module display_7seg_scan
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic [NUM_DIGITS-1:0]   load_blank,
   input  logic                    lz_suppress,
   output logic [SEG_W-1:0]        seg,
   output logic [NUM_DIGITS-1:0]   digit_sel
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic             POL_LOW  = (ACTIVE_LOW != 0);
   localparam logic [SEG_W-1:0]      SEG_OFF = apply_pol('0, POL_LOW);
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = POL_LOW ? '1 : '0;

   generate
      if (SCAN_DIV < 2 || NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_params
         $error("display_7seg_scan: illegal parameters (SCAN_DIV >= 2, NUM_DIGITS 1..8)");
      end
   endgenerate

   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;
   logic                    tick;
   logic                    pending;
   logic [4*NUM_DIGITS-1:0] disp_data;
   logic [NUM_DIGITS-1:0]   disp_blank;
   logic [4*NUM_DIGITS-1:0] shadow_data;
   logic [NUM_DIGITS-1:0]   shadow_blank;

   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   onehot;
   logic [3:0]              cur_nib;
   logic                    cur_blank;
   logic [SEG_W-1:0]        glyph;
   logic [SEG_W-1:0]        seg_lit;

   assign tick = (cnt == CNT_MAX);

   // A digit is a leading zero when it and every more significant digit are zero.
   always_comb begin
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run   = zero_run && (disp_data[4*i +: 4] == 4'h0);
         lz_mask[i] = (i > 0) && zero_run;
      end
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_blank = 1'b0;
      onehot    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib   = disp_data[4*i +: 4];
            cur_blank = disp_blank[i] | (lz_suppress & lz_mask[i]);
            onehot[i] = 1'b1;
         end
      end
   end

   hex_to_7seg u_hex (
      .nibble (cur_nib),
      .glyph  (glyph)
   );

   assign seg_lit = cur_blank ? '0 : glyph;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         idx          <= '0;
         disp_data    <= '0;
         disp_blank   <= '0;
         shadow_data  <= '0;
         shadow_blank <= '0;
         pending      <= 1'b0;
         load_ready   <= 1'b1;
         seg          <= SEG_OFF;
         digit_sel    <= SEL_OFF;
      end else begin
         cnt <= tick ? '0 : cnt + CNT_W'(1);
         if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end

         if (load_valid && load_ready) begin
            shadow_data  <= load_data;
            shadow_blank <= load_blank;
            pending      <= 1'b1;
            load_ready   <= 1'b0;
         end

         // Commit only at the frame wrap so a frame never mixes old and new digits.
         if (tick && idx == IDX_LAST && pending) begin
            disp_data  <= shadow_data;
            disp_blank <= shadow_blank;
            pending    <= 1'b0;
            load_ready <= 1'b1;
         end

         if (tick) begin
            seg       <= SEG_OFF;
            digit_sel <= SEL_OFF;
         end else begin
            seg       <= apply_pol(seg_lit, POL_LOW);
            digit_sel <= POL_LOW ? ~onehot : onehot;
         end
      end
   end

endmodule

// File: tb/tb_display_7seg_scan.sv
// Directed bench for display_7seg_scan with 4 digits, 4-cycle slots, active-low outputs.
module tb_display_7seg_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [3:0]  load_blank;
   logic        lz_suppress;
   logic [6:0]  seg;
   logic [3:0]  digit_sel;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   display_7seg_scan #(
      .NUM_DIGITS (4),
      .SCAN_DIV   (4),
      .ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_data   (load_data),
      .load_blank  (load_blank),
      .lz_suppress (lz_suppress),
      .seg         (seg),
      .digit_sel   (digit_sel)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic slot(input string tag, input int n, input logic [3:0] sel, input logic [6:0] sv);
      step_to(n);
      chk({tag, "_sel"}, 16'(digit_sel), 16'(sel));
      chk({tag, "_seg"}, 16'(seg), 16'(sv));
   endtask

   initial begin
      logic [3:0] exp_sel;
      rst         = 1'b1;
      load_valid  = 1'b0;
      load_data   = 16'h0000;
      load_blank  = 4'h0;
      lz_suppress = 1'b0;

      // Reset held for three edges
      for (int r = 0; r < 3; r++) begin
         step();
         chk("rst_seg", 16'(seg), 16'h7F);
         chk("rst_sel", 16'(digit_sel), 16'hF);
         chk("rst_ready", 16'(load_ready), 16'h1);
      end
      rst = 1'b0;
      cyc = 0;

      // Free-run scan: 1 dead + 3 lit cycles per digit, 16-cycle frame
      for (int k = 1; k <= 32; k++) begin
         step();
         if (k % 4 == 0) begin
            chk("scan_dead_sel", 16'(digit_sel), 16'hF);
            chk("scan_dead_seg", 16'(seg), 16'h7F);
         end else begin
            exp_sel = ~(4'b0001 << (((k - 1) / 4) % 4));
            chk("scan_lit_sel", 16'(digit_sel), 16'(exp_sel));
            chk("scan_lit_seg", 16'(seg), 16'h40);
         end
      end

      // Tear-free load offered while digit 1 is the scan index
      step_to(36);
      load_valid = 1'b1;
      load_data  = 16'h12AF;
      step();
      chk("tf_ready_low", 16'(load_ready), 16'h0);
      load_valid = 1'b0;
      load_data  = 16'h5555;
      chk("tf_old_d1_sel", 16'(digit_sel), 16'hD);
      chk("tf_old_d1_seg", 16'(seg), 16'h40);
      slot("tf_old_d2", 41, 4'hB, 7'h40);
      slot("tf_old_d3", 45, 4'h7, 7'h40);
      step_to(47);
      chk("tf_ready_held", 16'(load_ready), 16'h0);
      step_to(48);
      chk("tf_ready_back", 16'(load_ready), 16'h1);
      slot("tf_new_d0", 49, 4'hE, 7'h0E);
      slot("tf_new_d1", 53, 4'hD, 7'h08);
      slot("tf_new_d2", 57, 4'hB, 7'h24);
      slot("tf_new_d3", 61, 4'h7, 7'h79);

      // Back-pressure: 0003 taken, 0004 waits for the commit
      load_valid = 1'b1;
      load_data  = 16'h0003;
      step();
      load_data = 16'h0004;
      step_to(63);
      chk("bp_ready_low", 16'(load_ready), 16'h0);
      step_to(64);
      chk("bp_ready_commit", 16'(load_ready), 16'h1);
      step_to(65);
      load_valid = 1'b0;
      chk("bp_second_taken", 16'(load_ready), 16'h0);
      chk("bp_3_d0_seg", 16'(seg), 16'h30);
      slot("bp_3_d1", 69, 4'hD, 7'h40);
      step_to(80);
      chk("bp_ready_commit2", 16'(load_ready), 16'h1);
      slot("bp_4_d0", 81, 4'hE, 7'h19);

      // Leading-zero suppression with digit 0 force-blanked
      lz_suppress = 1'b1;
      load_valid  = 1'b1;
      load_data   = 16'h0030;
      load_blank  = 4'b0001;
      step();
      load_valid = 1'b0;
      slot("lz_d0_blank", 97, 4'hE, 7'h7F);
      slot("lz_d1_three", 101, 4'hD, 7'h30);
      slot("lz_d2_blank", 105, 4'hB, 7'h7F);
      slot("lz_d3_blank", 109, 4'h7, 7'h7F);

      load_valid = 1'b1;
      load_data  = 16'h0000;
      load_blank = 4'b0000;
      step();
      load_valid = 1'b0;
      slot("lz0_d0_zero", 113, 4'hE, 7'h40);
      slot("lz0_d1_blank", 117, 4'hD, 7'h7F);
      slot("lz0_d2_blank", 121, 4'hB, 7'h7F);
      slot("lz0_d3_blank", 125, 4'h7, 7'h7F);

      // Reset while BEEF is pending
      lz_suppress = 1'b0;
      load_valid  = 1'b1;
      load_data   = 16'hBEEF;
      step();
      load_valid = 1'b0;
      chk("mr_pending", 16'(load_ready), 16'h0);
      step();
      rst = 1'b1;
      step();
      step();
      chk("mr_rst_ready", 16'(load_ready), 16'h1);
      chk("mr_rst_sel", 16'(digit_sel), 16'hF);
      chk("mr_rst_seg", 16'(seg), 16'h7F);
      rst = 1'b0;
      cyc = 0;
      slot("mr_d0", 1, 4'hE, 7'h40);
      slot("mr_d1", 5, 4'hD, 7'h40);
      slot("mr_d2", 9, 4'hB, 7'h40);
      slot("mr_d3", 13, 4'h7, 7'h40);
      step_to(16);
      chk("mr_ready_after_wrap", 16'(load_ready), 16'h1);
      slot("mr_next_d0", 17, 4'hE, 7'h40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
